mod_accel_driver: RTL

- Sequencer directly upstream of the memory-mapped 16-bit modulo peripheral.
- Accepts an (x, y) operand pair from the core over a valid/ready request channel.
- Writes x to peripheral address 0 and y to address 1, then reads the remainder from address 2.
- Returns the remainder, plus an error flag, over a valid/ready response channel.
- Shields the core from the peripheral's address map and its read-latency timing.

---
 rtl/mod_accel_pkg.sv | 30 +++
 rtl/mod_accel_opcache.sv | 53 +++++
 rtl/mod_accel_driver.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mod_accel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod_accel_pkg
// Purpose  : Shared definitions for the modulo-peripheral sequencer:
//            sequencer state encoding, peripheral register map and
//            default widths.
// Revision : 1.0 - initial release
// ============================================================================
package mod_accel_pkg;

    localparam int OP_W_DEF   = 16;
    localparam int PER_W_DEF  = 32;
    localparam int ADDR_W_DEF = 2;

    // Peripheral register map
    localparam int ADDR_X   = 0;
    localparam int ADDR_Y   = 1;
    localparam int ADDR_RES = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR_X = 3'd1,
        ST_WR_Y = 3'd2,
        ST_RD   = 3'd3,
        ST_CAP  = 3'd4,
        ST_RESP = 3'd5
    } state_e;

endpackage : mod_accel_pkg
`default_nettype wire

// File: rtl/mod_accel_opcache.sv
`default_nettype none
// ============================================================================
// Module   : mod_accel_opcache
// Purpose  : Single-entry result cache for the modulo sequencer. Remembers
//            the last error-free (x, y, remainder) triple and flags a hit
//            when the presented operands match it.
// Ports    : clk_i, rst_n_i      - clock, async active-low reset
//            lk_x_i, lk_y_i      - operands to look up
//            hit_o, hit_res_o    - match flag and cached remainder
//            upd_i               - store upd_x_i/upd_y_i/upd_res_i
// Revision : 1.0 - initial release
// ============================================================================
module mod_accel_opcache
    import mod_accel_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [OP_W-1:0] lk_x_i,
    input  logic [OP_W-1:0] lk_y_i,
    output logic            hit_o,
    output logic [OP_W-1:0] hit_res_o,
    input  logic            upd_i,
    input  logic [OP_W-1:0] upd_x_i,
    input  logic [OP_W-1:0] upd_y_i,
    input  logic [OP_W-1:0] upd_res_i
);

    logic            vld_q;
    logic [OP_W-1:0] x_q;
    logic [OP_W-1:0] y_q;
    logic [OP_W-1:0] res_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            res_q <= '0;
        end else if (upd_i) begin
            vld_q <= 1'b1;
            x_q   <= upd_x_i;
            y_q   <= upd_y_i;
            res_q <= upd_res_i;
        end
    end

    assign hit_o     = vld_q && (lk_x_i == x_q) && (lk_y_i == y_q);
    assign hit_res_o = res_q;

endmodule : mod_accel_opcache
`default_nettype wire

// File: rtl/mod_accel_driver.sv
`default_nettype none
// ============================================================================
// Module   : mod_accel_driver
// Purpose  : Sequencer in front of the memory-mapped modulo peripheral.
//            Takes (x, y) on a valid/ready request channel, writes x and y
//            to the peripheral, reads back the remainder and returns it with
//            an error flag on a valid/ready response channel.
// Ports    : clk_i, rst_n_i                      - clock, async active-low reset
//            req_vld_i/req_rdy_o/req_x_i/req_y_i - request channel
//            rsp_vld_o/rsp_rdy_i/rsp_res_o/rsp_err_o - response channel
//            per_d_o/per_addr_o/per_w_o/per_r_o/per_e_o/per_out_i - peripheral
// Config   : MOD_ACCEL_DRIVER_OPCACHE_EN - when defined, repeats of the last
//            error-free operand pair are answered from a one-entry cache.
// Revision : 1.0 - initial release
// ============================================================================
module mod_accel_driver
    import mod_accel_pkg::*;
#(
    parameter int OP_W   = OP_W_DEF,
    parameter int PER_W  = PER_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_vld_i,
    output logic              req_rdy_o,
    input  logic [OP_W-1:0]   req_x_i,
    input  logic [OP_W-1:0]   req_y_i,
    output logic              rsp_vld_o,
    input  logic              rsp_rdy_i,
    output logic [OP_W-1:0]   rsp_res_o,
    output logic              rsp_err_o,
    output logic [OP_W-1:0]   per_d_o,
    output logic [ADDR_W-1:0] per_addr_o,
    output logic              per_w_o,
    output logic              per_r_o,
    output logic              per_e_o,
    input  logic [PER_W-1:0]  per_out_i
);

    state_e          state_q;
    logic [OP_W-1:0] x_q;
    logic [OP_W-1:0] y_q;
    logic [OP_W-1:0] res_q;
    logic            err_q;

    logic            w_hit;
    logic [OP_W-1:0] w_hit_res;
    logic            w_upper_err;

    assign w_upper_err = |per_out_i[PER_W-1:OP_W];

`ifdef MOD_ACCEL_DRIVER_OPCACHE_EN
    // Only error-free peripheral results are worth remembering.
    logic w_cache_upd;
    assign w_cache_upd = (state_q == ST_CAP) && !w_upper_err;

    mod_accel_opcache #(
        .OP_W (OP_W)
    ) u_opcache (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .lk_x_i    (req_x_i),
        .lk_y_i    (req_y_i),
        .hit_o     (w_hit),
        .hit_res_o (w_hit_res),
        .upd_i     (w_cache_upd),
        .upd_x_i   (x_q),
        .upd_y_i   (y_q),
        .upd_res_i (per_out_i[OP_W-1:0])
    );
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_vld_i) begin
                        x_q <= req_x_i;
                        y_q <= req_y_i;
                        if (req_y_i == '0) begin
                            // Divide-by-zero never reaches the peripheral.
                            res_q   <= '0;
                            err_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end else if (w_hit) begin
                            res_q   <= w_hit_res;
                            err_q   <= 1'b0;
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WR_X;
                        end
                    end
                end
                ST_WR_X: state_q <= ST_WR_Y;
                ST_WR_Y: state_q <= ST_RD;
                ST_RD:   state_q <= ST_CAP;
                ST_CAP: begin
                    // Peripheral read data became valid at the end of RD.
                    res_q   <= per_out_i[OP_W-1:0];
                    err_q   <= w_upper_err;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_rdy_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Ready is gated by reset directly so it drops the moment reset asserts.
    assign req_rdy_o = (state_q == ST_IDLE) && rst_n_i;
    assign rsp_vld_o = (state_q == ST_RESP);
    assign rsp_res_o = res_q;
    assign rsp_err_o = err_q;

    always_comb begin
        per_d_o    = '0;
        per_addr_o = '0;
        per_w_o    = 1'b0;
        per_r_o    = 1'b0;
        per_e_o    = 1'b0;
        case (state_q)
            ST_WR_X: begin
                per_e_o    = 1'b1;
                per_w_o    = 1'b1;
                per_addr_o = ADDR_W'(ADDR_X);
                per_d_o    = x_q;
            end
            ST_WR_Y: begin
                per_e_o    = 1'b1;
                per_w_o    = 1'b1;
                per_addr_o = ADDR_W'(ADDR_Y);
                per_d_o    = y_q;
            end
            ST_RD: begin
                per_e_o    = 1'b1;
                per_r_o    = 1'b1;
                per_addr_o = ADDR_W'(ADDR_RES);
            end
            default: ;
        endcase
    end

endmodule : mod_accel_driver
`default_nettype wire
